// File: rtl/el2_exu_ffmul_ctl.sv
// Sequencer for the finite-field multiply unit: validates the operand load beat
// stream, drives operand write strobes, runs the fixed-length multiply and flags errors.
module el2_exu_ffmul_ctl #(
  parameter int NUM_BEATS  = 7,
  parameter int MUL_CYCLES = 28,
  parameter int BEAT_W     = 3,
  parameter int STEP_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic              load_inc_i,
  input  logic              load_end_i,
  input  logic              rd_ack_i,
  input  logic              err_clr_i,
  output logic              load_we_o,
  output logic [BEAT_W-1:0] beat_idx_o,
  output logic              mul_start_o,
  output logic              step_en_o,
  output logic [STEP_W-1:0] step_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_CYCLES - 1);

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] cnt, cnt_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic              err, err_nxt;
  logic              new_err;

  logic any_load, multi_load, cnt_last;
  assign any_load   = load_start_i | load_inc_i | load_end_i;
  assign multi_load = (load_start_i & load_inc_i) | (load_start_i & load_end_i) |
                      (load_inc_i & load_end_i);
  assign cnt_last   = (cnt == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      step  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      step  <= step_nxt;
      err   <= err_nxt;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;
    new_err   = multi_load;
    case (state)
      S_IDLE: begin
        if (load_start_i) begin
          state_nxt = S_LOAD;
          cnt_nxt   = BEAT_W'(1);
        end else if (load_end_i || load_inc_i) begin
          new_err = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_start_i) begin
          cnt_nxt = BEAT_W'(1);
        end else if (load_end_i) begin
          if (cnt_last) begin
            state_nxt = S_RUN;
            step_nxt  = '0;
          end else begin
            state_nxt = S_IDLE;
            new_err   = 1'b1;
          end
        end else if (load_inc_i) begin
          if (cnt_last) new_err = 1'b1;
          else          cnt_nxt = cnt + BEAT_W'(1);
        end
      end
      S_RUN: begin
        // Load traffic during a run is an error but never perturbs the sequence.
        if (any_load) new_err = 1'b1;
        if (step == LAST_STEP) state_nxt = S_DONE;
        else                   step_nxt  = step + STEP_W'(1);
      end
      S_DONE: begin
        if (load_start_i) begin
          state_nxt = S_LOAD;
          cnt_nxt   = BEAT_W'(1);
        end else begin
          if (load_end_i || load_inc_i) new_err = 1'b1;
          if (rd_ack_i) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A clear coinciding with a fresh error leaves the flag set.
    err_nxt = (err & ~err_clr_i) | new_err;
  end

  always_comb begin
    load_we_o   = 1'b0;
    beat_idx_o  = '0;
    mul_start_o = 1'b0;
    step_en_o   = 1'b0;
    step_idx_o  = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = err;
    case (state)
      S_IDLE, S_DONE: begin
        load_we_o = load_start_i;
        done_o    = (state == S_DONE);
      end
      S_LOAD: begin
        if (load_start_i) begin
          load_we_o = 1'b1;
        end else if (load_end_i) begin
          load_we_o  = cnt_last;
          beat_idx_o = cnt_last ? cnt : '0;
        end else if (load_inc_i && !cnt_last) begin
          load_we_o  = 1'b1;
          beat_idx_o = cnt;
        end
      end
      S_RUN: begin
        mul_start_o = (step == '0);
        step_en_o   = 1'b1;
        step_idx_o  = step;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_el2_exu_ffmul_ctl.sv
// Self-checking bench for el2_exu_ffmul_ctl: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural sequence model.
module tb_el2_exu_ffmul_ctl;

  localparam int NUM_BEATS  = 7;
  localparam int MUL_CYCLES = 28;
  localparam int BEAT_W     = 3;
  localparam int STEP_W     = 5;

  logic clk = 1'b0;
  logic rst, load_start_i, load_inc_i, load_end_i, rd_ack_i, err_clr_i;
  logic              load_we_o;
  logic [BEAT_W-1:0] beat_idx_o;
  logic              mul_start_o, step_en_o;
  logic [STEP_W-1:0] step_idx_o;
  logic              busy_o, done_o, err_o;

  el2_exu_ffmul_ctl #(
    .NUM_BEATS(NUM_BEATS), .MUL_CYCLES(MUL_CYCLES), .BEAT_W(BEAT_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start_i), .load_inc_i(load_inc_i), .load_end_i(load_end_i),
    .rd_ack_i(rd_ack_i), .err_clr_i(err_clr_i),
    .load_we_o(load_we_o), .beat_idx_o(beat_idx_o),
    .mul_start_o(mul_start_o), .step_en_o(step_en_o), .step_idx_o(step_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: beats written so far in a load, cycles of multiply still to go.
  bit m_loading, m_done, m_err;
  int m_beats, m_left;

  // Outputs sampled in the most recent tick, for literal expectations.
  logic s_we, s_mul_start, s_step_en, s_busy, s_done, s_err;
  int   s_idx, s_step;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_err = 0; m_beats = 0; m_left = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic tick(input bit st, input bit inc, input bit en,
                      input bit ack, input bit clr, input bit r);
    bit run, e_we, nerr, multi;
    int e_idx;
    load_start_i = st; load_inc_i = inc; load_end_i = en;
    rd_ack_i = ack; err_clr_i = clr; rst = r;
    #1;
    run   = (m_left > 0);
    e_we  = 0;
    e_idx = 0;
    if (!run) begin
      if (st) e_we = 1;
      else if (m_loading && en) begin
        if (m_beats == NUM_BEATS - 1) begin e_we = 1; e_idx = m_beats; end
      end else if (m_loading && inc && m_beats < NUM_BEATS - 1) begin
        e_we = 1; e_idx = m_beats;
      end
    end
    check("load_we",   int'(load_we_o),   int'(e_we));
    check("beat_idx",  int'(beat_idx_o),  e_idx);
    check("mul_start", int'(mul_start_o), int'(run && m_left == MUL_CYCLES));
    check("step_en",   int'(step_en_o),   int'(run));
    check("step_idx",  int'(step_idx_o),  run ? MUL_CYCLES - m_left : 0);
    check("busy",      int'(busy_o),      int'(run));
    check("done",      int'(done_o),      int'(m_done));
    check("err",       int'(err_o),       int'(m_err));
    s_we = load_we_o; s_idx = int'(beat_idx_o); s_mul_start = mul_start_o;
    s_step_en = step_en_o; s_step = int'(step_idx_o); s_busy = busy_o;
    s_done = done_o; s_err = err_o;

    multi = (int'(st) + int'(inc) + int'(en)) > 1;
    nerr  = multi;
    if (run) nerr |= (st | inc | en);
    else if (!st) begin
      if (!m_loading) nerr |= (inc | en);
      else if (en)    nerr |= (m_beats != NUM_BEATS - 1);
      else if (inc)   nerr |= (m_beats == NUM_BEATS - 1);
    end

    @(posedge clk);
    if (r) model_reset();
    else begin
      m_err = (m_err & !clr) | nerr;
      if (run) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (st) begin
        m_loading = 1; m_beats = 1; m_done = 0;
      end else if (m_loading) begin
        if (en) begin
          m_loading = 0;
          if (m_beats == NUM_BEATS - 1) m_left = MUL_CYCLES;
        end else if (inc && m_beats < NUM_BEATS - 1) m_beats++;
      end else if (m_done && ack) m_done = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    bit st, inc, en;
    model_reset();
    load_start_i = 0; load_inc_i = 0; load_end_i = 0;
    rd_ack_i = 0; err_clr_i = 0; rst = 1;
    @(posedge clk); #1;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    idle(1);
    check("reset_busy", int'(s_busy), 0);
    check("reset_done", int'(s_done), 0);
    check("reset_err",  int'(s_err),  0);

    // Clean sequence: beats 0..6 then a full run.
    tick(1, 0, 0, 0, 0, 0);
    check("lit_first_idx", s_idx, 0);
    for (int b = 1; b < 6; b++) begin
      tick(0, 1, 0, 0, 0, 0);
      check("lit_inc_idx", s_idx, b);
    end
    tick(0, 0, 1, 0, 0, 0);
    check("lit_end_we",  int'(s_we), 1);
    check("lit_end_idx", s_idx, 6);
    for (int j = 1; j <= MUL_CYCLES; j++) begin
      idle(1);
      if (j == 1) check("lit_mul_start", int'(s_mul_start), 1);
    end
    check("lit_last_step", s_step, 27);
    check("lit_not_done_yet", int'(s_done), 0);
    idle(1);
    check("lit_done", int'(s_done), 1);
    check("lit_err_clean", int'(s_err), 0);
    tick(0, 0, 0, 1, 0, 0);

    // Short sequence: end after beat 3 aborts without launch.
    tick(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 3; b++) tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    check("lit_short_no_we", int'(s_we), 0);
    idle(2);
    check("lit_short_err", int'(s_err), 1);
    check("lit_short_idle", int'(s_busy), 0);
    tick(0, 0, 0, 0, 1, 0);

    // Overflow inc, then a valid end still launches; inc during step 10.
    tick(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 6; b++) tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    check("lit_ovf_no_we", int'(s_we), 0);
    tick(0, 0, 1, 0, 0, 0);
    check("lit_ovf_end_idx", s_idx, 6);
    check("lit_ovf_err", int'(s_err), 1);
    tick(0, 0, 0, 0, 1, 0);
    for (int j = 2; j <= MUL_CYCLES + 1; j++) begin
      if (j == 11) tick(0, 1, 0, 0, 0, 0);
      else         idle(1);
    end
    check("lit_run_done", int'(s_done), 1);
    check("lit_run_err", int'(s_err), 1);
    tick(0, 0, 0, 1, 1, 0);

    // start+end together in IDLE, clear, then clear colliding with an error.
    tick(1, 0, 1, 0, 0, 0);
    check("lit_dual_we", int'(s_we), 1);
    tick(0, 0, 0, 0, 1, 0);
    check("lit_dual_err", int'(s_err), 1);
    idle(1);
    check("lit_cleared", int'(s_err), 0);
    tick(1, 1, 0, 0, 1, 0);
    idle(1);
    check("lit_clr_collide", int'(s_err), 1);

    // Reset in the middle of a run.
    for (int b = 0; b < 5; b++) tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    for (int j = 1; j <= 5; j++) idle(1);
    tick(0, 0, 0, 0, 0, 1);
    check("lit_rst_step", s_step, 5);
    idle(1);
    check("lit_rst_busy", int'(s_busy), 0);
    check("lit_rst_step_en", int'(s_step_en), 0);
    check("lit_rst_done", int'(s_done), 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 5; b++) tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    idle(MUL_CYCLES + 1);
    check("lit_fresh_done", int'(s_done), 1);

    // Randomized traffic, biased toward legal sequences with sporadic noise.
    for (int c = 0; c < 4000; c++) begin
      st = 0; inc = 0; en = 0;
      r = $urandom_range(99, 0);
      if (m_left > 0) begin
        if (r < 3) inc = 1; else if (r < 5) en = 1; else if (r < 6) st = 1;
      end else if (m_loading) begin
        if (m_beats < NUM_BEATS - 1) begin
          if (r < 70) inc = 1; else if (r < 74) en = 1; else if (r < 77) st = 1;
        end else begin
          if (r < 50) en = 1; else if (r < 58) inc = 1; else if (r < 60) st = 1;
        end
      end else begin
        if (r < 15) st = 1; else if (r < 18) inc = 1; else if (r < 20) en = 1;
      end
      if ($urandom_range(99, 0) < 4) inc = 1;
      if ($urandom_range(99, 0) < 2) en = 1;
      tick(st, inc, en, $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 5,
           $urandom_range(399, 0) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
